mac_feeder: RTL and testbench

Operand issue stage driving the 8-lane signed MAC array. It accepts activation/weight chunk pairs over a valid/ready handshake and buffers them in a small FIFO. Each cycle it presents one chunk to the MAC, driving zeros when idle. It also emits valid/first/last tags aligned with the MAC's registered partial-sum output, so the downstream accumulator knows which psum cycles belong to which dot product.

---
 rtl/mac_pkg.sv | 18 +
 rtl/feeder_fifo.sv | 78 +++++++
 rtl/mac_feeder.sv | 155 +++++++++++++++
 tb/tb_mac_feeder.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// Shared constants and types for the MAC operand feeder.
//   BW/PR/DEPTH/KW : default lane width, lane count, FIFO depth, chunk-count width
//   LANE_W         : packed width of one operand chunk (PR lanes of BW bits)
//   state_e        : dot-product sequencing state
package mac_pkg;

    localparam int unsigned BW     = 8;
    localparam int unsigned PR     = 8;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned KW     = 8;
    localparam int unsigned LANE_W = PR * BW;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/feeder_fifo.sv
// Synchronous FIFO buffering activation/weight chunk pairs.
//   clk, reset  : clock, synchronous active-low reset
//   push_i      : write wdata_i (ignored when full)
//   wdata_i     : entry to store
//   pop_i       : drop head entry (ignored when empty)
//   rdata_o     : head entry
//   full_o      : no free entry (held high during reset so nothing is accepted)
//   empty_o     : no stored entry
module feeder_fifo
    import mac_pkg::*;
#(
    parameter int unsigned dw    = 2 * LANE_W,
    parameter int unsigned depth = DEPTH
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push_i,
    input  logic [dw-1:0] wdata_i,
    input  logic          pop_i,
    output logic [dw-1:0] rdata_o,
    output logic          full_o,
    output logic          empty_o
);

    localparam int unsigned AW = (depth > 1) ? $clog2(depth) : 1;
    localparam int unsigned CW = AW + 1;

    logic [dw-1:0] mem_q [depth];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic          do_push;
    logic          do_pop;

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign rdata_o = mem_q[rd_ptr_q];

    // Occupancy: simultaneous push and pop leaves it unchanged.
    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + CW'(1);
        end else if (!do_push && do_pop) begin
            count_d = count_q - CW'(1);
        end
    end

    // Pointers and flags; flags are registered from the next occupancy.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            empty_o  <= 1'b1;
            full_o   <= 1'b1;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_d;
            empty_o <= (count_d == '0);
            full_o  <= (count_d == CW'(depth));
        end
    end

    // Storage array, no reset needed.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/mac_feeder.sv
// Operand issue stage for the 8-lane signed MAC array. Buffers chunk pairs,
// issues one per cycle (zeros when idle) and emits psum tags aligned with the
// MAC's registered output. The MAC's active-high reset is driven from ~reset.
// Optional feature macro: MAC_FEEDER_ZERO_SKIP_EN (zero-operand chunks issued
// as zeros and counted on skip_cnt).
//   clk, reset          : clock, synchronous active-low reset
//   in_valid/in_ready   : chunk handshake
//   in_a, in_b          : activation / weight lanes
//   cfg_k               : chunks per dot product (0 acts as 1)
//   mac_a, mac_b        : registered MAC operands
//   psum_valid/first/last : tags for the MAC output cycle
//   busy                : work buffered or dot product in progress
//   skip_cnt            : skipped chunk count (macro only)
module mac_feeder
    import mac_pkg::*;
#(
    parameter int unsigned bw    = BW,
    parameter int unsigned pr    = PR,
    parameter int unsigned depth = DEPTH,
    parameter int unsigned kw    = KW
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [pr*bw-1:0] in_a,
    input  logic [pr*bw-1:0] in_b,
    input  logic [kw-1:0]    cfg_k,
    output logic [pr*bw-1:0] mac_a,
    output logic [pr*bw-1:0] mac_b,
    output logic             psum_valid,
    output logic             psum_first,
    output logic             psum_last,
    output logic             busy
`ifdef MAC_FEEDER_ZERO_SKIP_EN
    ,
    output logic [15:0]      skip_cnt
`endif
);

    localparam int unsigned LW = pr * bw;

    logic [2*LW-1:0] head;
    logic [LW-1:0]   head_a;
    logic [LW-1:0]   head_b;
    logic            fifo_full;
    logic            fifo_empty;
    logic            push;
    logic            pop;
    logic            skip;
    logic [kw-1:0]   k_eff;

    state_e          state_q;
    logic [kw-1:0]   k_q;
    logic [kw-1:0]   idx_q;
    logic            iv_q;
    logic            if_q;
    logic            il_q;

    assign in_ready = !fifo_full;
    assign push     = in_valid && in_ready;
    // The MAC never stalls, so anything buffered is issued immediately.
    assign pop      = !fifo_empty;
    assign head_a   = head[2*LW-1:LW];
    assign head_b   = head[LW-1:0];
    assign k_eff    = (cfg_k == '0) ? kw'(1) : cfg_k;
    assign busy     = !fifo_empty || (state_q == ST_RUN);

`ifdef MAC_FEEDER_ZERO_SKIP_EN
    assign skip = (head_a == '0) || (head_b == '0);
`else
    assign skip = 1'b0;
`endif

    feeder_fifo #(
        .dw    (2 * LW),
        .depth (depth)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push),
        .wdata_i ({in_a, in_b}),
        .pop_i   (pop),
        .rdata_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Sequencer, issue registers and the one-stage tag delay matching the MAC.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            k_q        <= '0;
            idx_q      <= '0;
            mac_a      <= '0;
            mac_b      <= '0;
            iv_q       <= 1'b0;
            if_q       <= 1'b0;
            il_q       <= 1'b0;
            psum_valid <= 1'b0;
            psum_first <= 1'b0;
            psum_last  <= 1'b0;
        end else begin
            iv_q  <= pop;
            if_q  <= 1'b0;
            il_q  <= 1'b0;
            mac_a <= '0;
            mac_b <= '0;
            if (pop && !skip) begin
                mac_a <= head_a;
                mac_b <= head_b;
            end
            psum_valid <= iv_q;
            psum_first <= if_q;
            psum_last  <= il_q;
            if (pop) begin
                case (state_q)
                    ST_IDLE: begin
                        if_q <= 1'b1;
                        k_q  <= k_eff;
                        if (k_eff == kw'(1)) begin
                            il_q <= 1'b1;
                        end else begin
                            state_q <= ST_RUN;
                            idx_q   <= kw'(1);
                        end
                    end
                    ST_RUN: begin
                        // k_q is frozen for the whole product.
                        if (idx_q == k_q - kw'(1)) begin
                            il_q    <= 1'b1;
                            state_q <= ST_IDLE;
                            idx_q   <= '0;
                        end else begin
                            idx_q <= idx_q + kw'(1);
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

`ifdef MAC_FEEDER_ZERO_SKIP_EN
    // Saturating count of chunks issued as zeros.
    always_ff @(posedge clk) begin
        if (!reset) begin
            skip_cnt <= '0;
        end else if (pop && skip && (skip_cnt != 16'hFFFF)) begin
            skip_cnt <= skip_cnt + 16'(1);
        end
    end
`endif

endmodule

// File: tb/tb_mac_feeder.sv
// Scoreboard bench for mac_feeder: accepted chunks push expected issue and
// psum entries; negedge monitor checks them at their due cycle.
module tb_mac_feeder;
    import mac_pkg::*;

    localparam int unsigned LW = LANE_W;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [LW-1:0] in_a;
    logic [LW-1:0] in_b;
    logic [KW-1:0] cfg_k;
    logic [LW-1:0] mac_a;
    logic [LW-1:0] mac_b;
    logic          psum_valid;
    logic          psum_first;
    logic          psum_last;
    logic          busy;
`ifdef MAC_FEEDER_ZERO_SKIP_EN
    logic [15:0]   skip_cnt;
`endif

    always #5 clk = ~clk;

    mac_feeder dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .cfg_k      (cfg_k),
        .mac_a      (mac_a),
        .mac_b      (mac_b),
        .psum_valid (psum_valid),
        .psum_first (psum_first),
        .psum_last  (psum_last),
        .busy       (busy)
`ifdef MAC_FEEDER_ZERO_SKIP_EN
        ,
        .skip_cnt   (skip_cnt)
`endif
    );

    typedef struct {
        int dot;
        bit first;
        bit last;
        int cyc;
    } exp_t;

    typedef struct {
        logic [LW-1:0] a;
        logic [LW-1:0] b;
        int            cyc;
    } iss_t;

    exp_t exp_q[$];
    iss_t iss_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   pos = 0;
    int   klat = 1;
    int   skip_model = 0;
    int   mac_out;
    bit   rst_s = 1'b0;
    bit   started = 1'b0;
    logic [LW-1:0] ra;
    logic [LW-1:0] rb;
    int   n;

    task automatic check(input string name, input bit ok, input longint act, input longint expv);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    function automatic int dot8(input logic [LW-1:0] a, input logic [LW-1:0] b);
        int s;
        logic signed [BW-1:0] la;
        logic signed [BW-1:0] lb;
        s = 0;
        for (int i = 0; i < int'(PR); i++) begin
            la = a[i*BW +: BW];
            lb = b[i*BW +: BW];
            s += int'(la) * int'(lb);
        end
        return s;
    endfunction

    // Reference MAC: registered signed dot product of the issued operands.
    always @(posedge clk) begin
        if (!reset) mac_out <= 0;
        else        mac_out <= dot8(mac_a, mac_b);
    end

    // Reference model: every accepted chunk yields one issue and one psum,
    // tagged by its position inside the current k-chunk product.
    always @(posedge clk) begin
        exp_t e;
        iss_t s;
        cyc++;
        started = 1'b1;
        rst_s   = reset;
        if (!reset) begin
            exp_q.delete();
            iss_q.delete();
            pos        = 0;
            skip_model = 0;
        end else if (in_valid && in_ready) begin
            if (pos == 0) klat = (cfg_k == '0) ? 1 : int'(cfg_k);
            e.dot   = dot8(in_a, in_b);
            e.first = (pos == 0);
            e.last  = (pos == klat - 1);
            e.cyc   = cyc;
            pos     = e.last ? 0 : pos + 1;
            exp_q.push_back(e);
            s.a   = in_a;
            s.b   = in_b;
            s.cyc = cyc;
            iss_q.push_back(s);
        end
    end

    // Monitor: issue due one edge after acceptance, psum two edges after.
    always @(negedge clk) begin
        exp_t e;
        iss_t s;
        logic [LW-1:0] ea;
        logic [LW-1:0] eb;
        if (started) begin
            if (!rst_s) begin
                check("rst_in_ready", in_ready == 1'b0, longint'(in_ready), 0);
                check("rst_mac", (mac_a == '0) && (mac_b == '0), longint'(mac_a | mac_b), 0);
                check("rst_psum", {psum_valid, psum_first, psum_last} == 3'b000,
                      longint'({psum_valid, psum_first, psum_last}), 0);
                check("rst_busy", busy == 1'b0, longint'(busy), 0);
`ifdef MAC_FEEDER_ZERO_SKIP_EN
                check("rst_skip_cnt", skip_cnt == 16'h0, longint'(skip_cnt), 0);
`endif
            end else begin
                check("in_ready", in_ready == 1'b1, longint'(in_ready), 1);
                if (iss_q.size() != 0 && iss_q[0].cyc + 1 == cyc) begin
                    s  = iss_q.pop_front();
                    ea = s.a;
                    eb = s.b;
`ifdef MAC_FEEDER_ZERO_SKIP_EN
                    if (s.a == '0 || s.b == '0) begin
                        ea = '0;
                        eb = '0;
                        if (skip_model < 65535) skip_model++;
                    end
`endif
                    check("mac_a", mac_a == ea, longint'(mac_a), longint'(ea));
                    check("mac_b", mac_b == eb, longint'(mac_b), longint'(eb));
                end else begin
                    check("gap_zero", (mac_a == '0) && (mac_b == '0), longint'(mac_a | mac_b), 0);
                end
                if (exp_q.size() != 0 && exp_q[0].cyc + 2 == cyc) begin
                    e = exp_q.pop_front();
                    check("psum_valid", psum_valid == 1'b1, longint'(psum_valid), 1);
                    if (psum_valid) begin
                        check("psum_dot", mac_out == e.dot, mac_out, e.dot);
                        check("psum_first", psum_first == e.first, longint'(psum_first), longint'(e.first));
                        check("psum_last", psum_last == e.last, longint'(psum_last), longint'(e.last));
                    end
                end else begin
                    check("psum_idle", psum_valid == 1'b0, longint'(psum_valid), 0);
                end
`ifdef MAC_FEEDER_ZERO_SKIP_EN
                check("skip_cnt", skip_cnt == 16'(skip_model), longint'(skip_cnt), skip_model);
`endif
            end
        end
    end

    task automatic idle(input int cycles);
        repeat (cycles) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    task automatic send(input logic [LW-1:0] a, input logic [LW-1:0] b);
        int w;
        @(negedge clk);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        w        = 0;
        while (!in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        check("send_ready", in_ready == 1'b1, longint'(in_ready), 1);
    endtask

    task automatic rand_chunk(output logic [LW-1:0] a, output logic [LW-1:0] b);
        a = LW'({$urandom, $urandom});
        b = LW'({$urandom, $urandom});
        if ($urandom_range(0, 5) == 0) a = '0;
        if ($urandom_range(0, 5) == 0) b = '0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b0;
        in_valid = 1'b0;
        in_a     = '0;
        in_b     = '0;
        cfg_k    = KW'(1);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        idle(2);

        // k=3, lanes a=-1 b=2: each psum -16, first/last on chunks 0/2.
        cfg_k = KW'(3);
        ra = {8{8'hFF}};
        rb = {8{8'h02}};
        repeat (3) send(ra, rb);
        idle(6);

        // k=0 behaves as k=1.
        cfg_k = KW'(0);
        repeat (2) begin
            rand_chunk(ra, rb);
            send(ra, rb);
        end
        idle(6);

        // Bursty upstream with in_valid gaps.
        cfg_k = KW'(2);
        for (int c = 0; c < 16; c++) begin
            if ($urandom_range(0, 1) == 0) begin
                rand_chunk(ra, rb);
                send(ra, rb);
            end else begin
                idle(1);
            end
        end
        idle(6);

        // Reset while idx==1 of a k=4 product, then a fresh k=2 product.
        cfg_k = KW'(4);
        rand_chunk(ra, rb);
        send(ra, rb);
        idle(2);
        check("busy_run", busy == 1'b1, longint'(busy), 1);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        idle(2);
        cfg_k = KW'(2);
        repeat (2) begin
            rand_chunk(ra, rb);
            send(ra, rb);
        end
        idle(6);
        check("busy_idle", busy == 1'b0, longint'(busy), 0);

        // Zero weight chunk followed by a nonzero one, k=2.
        cfg_k = KW'(2);
        ra = LW'({$urandom, $urandom}) | LW'(1);
        send(ra, '0);
        ra = LW'({$urandom, $urandom}) | LW'(1);
        rb = LW'({$urandom, $urandom}) | LW'(1);
        send(ra, rb);
        idle(6);

        // Randomized segments with gaps, mid-product cfg_k changes and resets.
        for (int sg = 0; sg < 40; sg++) begin
            cfg_k = KW'($urandom_range(0, 5));
            n = $urandom_range(1, 12);
            for (int c = 0; c < n; c++) begin
                if ($urandom_range(0, 3) == 0) idle(1);
                if (c == n / 2 && $urandom_range(0, 2) == 0) begin
                    idle(3);
                    cfg_k = KW'($urandom_range(0, 5));
                end
                rand_chunk(ra, rb);
                send(ra, rb);
            end
            if ($urandom_range(0, 7) == 0) begin
                idle(1);
                reset = 1'b0;
                @(negedge clk);
                reset = 1'b1;
            end
            idle(3);
        end

        idle(6);
        check("drained", exp_q.size() == 0 && iss_q.size() == 0, exp_q.size() + iss_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
